// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encodings and the default operand width.
package arith_pkg;

  localparam int unsigned ARITH_N = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRun  = RUN,
    StDone = DONE
  } state_e;

endpackage

// File: rtl/RCA.sv
// N-bit ripple-carry adder; the carry chain through N full adders is the critical path.
module RCA #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out
);

  logic [N:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN shift-and-add multiplier, one multiplier bit per cycle,
// with valid/ready handshakes on operands and product.
module shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int unsigned N = ARITH_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  localparam int unsigned   CntW    = $clog2(N + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(N);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  state_e           state_q;
  logic [N-1:0]     m_q;
  logic [2*N:0]     p_q;
  logic [CntW-1:0]  cnt_q;
  logic [2*N-1:0]   product_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [N-1:0]     addend;
  logic [N-1:0]     sum;
  logic             carry;
  logic [2*N:0]     p_shift;
  logic             unused_p_msb;

  assign addend = p_q[0] ? m_q : '0;

  RCA #(
    .N(N)
  ) u_rca (
    .a    (p_q[2*N-1:N]),
    .b    (addend),
    .c_in (1'b0),
    .s    (sum),
    .c_out(carry)
  );

  // Carry lands in the hi MSB after the shift, so the top bit of P is always zero here.
  assign p_shift      = {1'b0, carry, sum, p_q[N-1:1]};
  assign unused_p_msb = p_q[2*N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      m_q         <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            m_q        <= a;
            p_q        <= {1'b0, {N{1'b0}}, b};
            cnt_q      <= CntInit;
            state_q    <= StRun;
            in_ready_q <= 1'b0;
          end
        end
        StRun: begin
          p_q   <= p_shift;
          cnt_q <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            product_q   <= p_shift[2*N-1:0];
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned N×N multiplier that produces a 2N-bit product with the shift-and-add algorithm, one multiplier bit per clock. It sits directly upstream of and around the team's N-bit ripple-carry adder: each cycle it feeds the adder the accumulator high half and the multiplicand, then consumes the sum and carry. Operands enter through a valid/ready handshake and the product leaves through one, so the block drops into streaming arithmetic datapaths.

## Interface
- `N`, default 8: operand width; product is 2N bits; N ≥ 2.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: operands `a`, `b` are valid.
- `in_ready` output, 1 bit: block can accept operands; high only in IDLE.
- `a` input, N bits: multiplicand, unsigned.
- `b` input, N bits: multiplier, unsigned.
- `out_valid` output, 1 bit: `product` is valid; high only in DONE.
- `out_ready` input, 1 bit: consumer accepts `product`.
- `product` output, 2N bits: registered result.

## Operation
- Registers:
  - M (N bits): multiplicand.
  - P (2N+1 bits): {carry, hi[N-1:0], lo[N-1:0]}.
  - cnt: $clog2(N+1) bits.
  - product_r (2N bits).
  - state.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, load M←a, P←{1'b0, N'b0, b}, cnt←N, then go to RUN.
  - RUN: every cycle, compute {c, s} = hi + (P[0] ? M : 0) through the adder with c_in=0. Then P←{1'b0, c, s, lo} >> 1 and cnt←cnt−1. When cnt==1 at the edge, write product_r←the shifted value's low 2N bits and go to DONE.
  - DONE: `out_valid`=1 and `product` = product_r, held stable. On `out_ready`, go to IDLE.
- Arithmetic is unsigned only. The adder carry-out must be retained in P so that hi never overflows. The maximum result, (2^N−1)^2, fits in 2N bits.
- `in_valid` outside IDLE is ignored; operands are not buffered.
- `out_ready` outside DONE is ignored.
- `product` shows only product_r and never partial sums. It keeps the last result until the next completion.
- `rst_n` low at any time, including mid-RUN or during DONE:
  - immediate return to IDLE;
  - P, M, cnt, product_r cleared;
  - the in-flight operation is discarded and no `out_valid` pulse is produced.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `product`=0, state=IDLE.
- Accept edge t0: state becomes RUN.
- RUN occupies exactly N cycles (edges t0+1 … t0+N).
- `out_valid` is high from edge t0+N, so latency is N cycles from acceptance to valid result.
- DONE with `out_ready`=1 lasts one cycle. IDLE follows at edge t0+N+1, and the next accept is possible at edge t0+N+2.
- Minimum initiation interval: N+2 cycles.
- Backpressure: while `out_ready`=0, DONE persists indefinitely with `product` constant and `in_ready`=0.
- `in_ready` and `out_valid` are decoded from state only, with no combinational path from the inputs.
- The adder path is combinational within one cycle. The RCA depth of N full adders sets the critical path.

## Structure
- Shared package `arith_pkg`:
  - state localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default width localparam ARITH_N=8.
- Sub-module: one instance of the existing `RCA` with N=`N`, c_in tied 0, operands hi and gated M. No other adder logic in this block.
- Counter, FSM, and the P/M/product_r registers live in the top module.

## Test plan
- Reset:
  - Assert `rst_n`=0 with random inputs → `in_ready`=1, `out_valid`=0, `product`=16'h0000.
  - Release → IDLE.
- Basic multiply:
  - a=13, b=11, N=8 → `out_valid` rises exactly 8 cycles after the accept edge, with `product`=16'h008F.
  - `in_ready`=0 throughout RUN and DONE.
- Carry path:
  - a=255, b=255 → `product`=16'hFE01.
  - a=128, b=2 → 16'h0100.
  - a=0, b=200 → 16'h0000.
- Backpressure:
  - After 13×11, hold `out_ready`=0 for 5 cycles while driving `in_valid`=1 with a=3, b=3 → `product` stays 16'h008F and no new accept occurs.
  - After `out_ready`=1, the next accept of 3×3 gives 16'h0009.
- Mid-operation reset:
  - Pulse `rst_n` low 4 cycles into RUN of 100×100 → no `out_valid` and `product`=0.
  - Then 7×6 → 16'h002A after 8 cycles.
- Parameterisation:
  - N=4, a=15, b=15 → 8'hE1 after 4 cycles.
  - Random back-to-back sweep of 1000 operands with a random `out_ready` pattern → every product matches a×b.
